// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer for the 16x16 register file: fetches two registers
// per cycle through both read ports and streams {index, value} over valid/ready.
module regfile_dump_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] readReg1,
    output logic [ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(32'd2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(32'd2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND0 = 3'd2,
        S_SEND1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   buf1_addr_q, buf1_addr_d;
    logic [DATA_W-1:0]   buf1_data_q, buf1_data_d;
    logic                buf1_vld_q, buf1_vld_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   rd1_q, rd1_d;
    logic [ADDR_W-1:0]   rd2_q, rd2_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   diff_s;
    logic [CNT_W-1:0]    len_s;
    logic                hs_s;

    // Range length wraps mod 16, so first==last is one register and 0..15 is sixteen.
    assign diff_s = last_reg - first_reg;
    assign len_s  = {1'b0, diff_s} + CNT_ONE;
    assign hs_s   = out_valid_q && out_ready;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        buf1_addr_d = buf1_addr_q;
        buf1_data_d = buf1_data_q;
        buf1_vld_d  = buf1_vld_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = first_reg;
                    rem_d   = len_s;
                    rd1_d   = first_reg;
                    rd2_d   = first_reg + ADDR_ONE;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                out_addr_d  = ptr_q;
                out_data_d  = readData1;
                out_valid_d = 1'b1;
                if (rem_q >= CNT_TWO) begin
                    buf1_addr_d = ptr_q + ADDR_ONE;
                    buf1_data_d = readData2;
                    buf1_vld_d  = 1'b1;
                    ptr_d       = ptr_q + ADDR_TWO;
                end else begin
                    buf1_vld_d  = 1'b0;
                    ptr_d       = ptr_q + ADDR_ONE;
                end
                state_d = S_SEND0;
            end
            S_SEND0: begin
                if (hs_s) begin
                    rem_d = rem_q - CNT_ONE;
                    if (buf1_vld_q) begin
                        out_addr_d = buf1_addr_q;
                        out_data_d = buf1_data_q;
                        state_d    = S_SEND1;
                    end else if (rem_q == CNT_ONE) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        out_valid_d = 1'b0;
                        rd1_d       = ptr_q;
                        rd2_d       = ptr_q + ADDR_ONE;
                        state_d     = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND0;
                end
            end
            S_SEND1: begin
                if (hs_s) begin
                    rem_d       = rem_q - CNT_ONE;
                    out_valid_d = 1'b0;
                    buf1_vld_d  = 1'b0;
                    if (rem_q == CNT_ONE) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd1_d   = ptr_q;
                        rd2_d   = ptr_q + ADDR_ONE;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to zero/IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            buf1_addr_q <= '0;
            buf1_data_q <= '0;
            buf1_vld_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            buf1_addr_q <= buf1_addr_d;
            buf1_data_q <= buf1_data_d;
            buf1_vld_q  <= buf1_vld_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign readReg1  = rd1_q;
    assign readReg2  = rd2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register-file model, queue-based expected stream,
// per-cycle compare process and directed literal checks followed by random dumps.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  first_reg, last_reg;
    logic [3:0]  readReg1, readReg2;
    logic [15:0] readData1, readData2;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_addr;
    logic        busy, done;

    logic [15:0] rf [16];
    logic [15:0] rf_init [16];

    int n_vec = 0;
    int n_err = 0;
    int ready_mode = 0;

    logic [19:0] exp_q [$];
    logic [19:0] obs_q [$];
    bit          active, last_acc, prev_stall;
    logic [19:0] prev_word;

    regfile_dump_reader #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_reg(first_reg), .last_reg(last_reg),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    assign readData1 = rf[readReg1];
    assign readData2 = rf[readReg2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Per-cycle compare against the queue model; the model advances at each negedge
    // to reflect what the coming rising edge does.
    always @(negedge clk) begin
        logic [19:0] w;
        logic [3:0]  d4;
        logic [3:0]  a;
        bit          hs, was_active;
        if (!rst) begin
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            exp_q.delete();
            active = 1'b0;
            last_acc = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done", done, last_acc);
            chk("busy", busy, active && !last_acc);
            if (out_valid) chk("valid_window", active && !last_acc, 1'b1);
            if (prev_stall) begin
                chk("valid_hold", out_valid, 1'b1);
                chk("stall_hold", {out_addr, out_data}, prev_word);
            end
            hs = out_valid && out_ready;
            if (hs) begin
                obs_q.push_back({out_addr, out_data});
                if (exp_q.size() == 0) fail_now("extra_beat");
                else begin
                    w = exp_q.pop_front();
                    chk("beat", {out_addr, out_data}, w);
                end
            end
            was_active = active;
            if (last_acc) begin
                active = 1'b0;
                last_acc = 1'b0;
            end else if (hs && active && exp_q.size() == 0) begin
                last_acc = 1'b1;
            end
            if (!was_active && start) begin
                active = 1'b1;
                d4 = last_reg - first_reg;
                for (int i = 0; i <= int'(d4); i++) begin
                    a = first_reg + 4'(i);
                    exp_q.push_back({a, rf[a]});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word = {out_addr, out_data};
        end
    end

    // Consumer ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random, 3 stalled.
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2: out_ready = 1'($urandom);
                default: out_ready = 1'b0;
            endcase
            ph++;
        end
    end

    task automatic do_start(input logic [3:0] f, input logic [3:0] l);
        first_reg = f;
        last_reg = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) fail_now("done_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rf_init = '{16'h0000, 16'h0F00, 16'h1010, 16'hFF0F, 16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
                    16'hAAAA, 16'h5555, 16'h0123, 16'h4567, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
        rf = rf_init;
        start = 1'b0;
        first_reg = 4'd0;
        last_reg = 4'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {out_valid, busy, done, readReg1, readReg2, out_addr, out_data}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // full dump, ready high
        obs_q.delete();
        do_start(4'd0, 4'd15);
        wait_done(100);
        chk("full_count", obs_q.size(), 32'd16);
        if (obs_q.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("full_addr", obs_q[i][19:16], 32'(i));
            chk("full_r1", obs_q[1][15:0], 16'h0F00);
            chk("full_r3", obs_q[3][15:0], 16'hFF0F);
            chk("full_r8", obs_q[8][15:0], 16'hAAAA);
            chk("full_r12", obs_q[12][15:0], 16'hFFFF);
            chk("full_r13", obs_q[13][15:0], 16'h0002);
        end

        // same dump under 1,0,0,1 backpressure
        ready_mode = 1;
        obs_q.delete();
        do_start(4'd0, 4'd15);
        wait_done(200);
        chk("bp_count", obs_q.size(), 32'd16);
        if (obs_q.size() == 16)
            for (int i = 0; i < 16; i++) chk("bp_word", obs_q[i], {4'(i), rf_init[i]});
        ready_mode = 0;

        // wrap-around range 14..1
        obs_q.delete();
        do_start(4'd14, 4'd1);
        wait_done(100);
        chk("wrap_count", obs_q.size(), 32'd4);
        if (obs_q.size() == 4) begin
            chk("wrap_b0", obs_q[0], {4'd14, 16'h0000});
            chk("wrap_b1", obs_q[1], {4'd15, 16'h0000});
            chk("wrap_b2", obs_q[2], {4'd0, 16'h0000});
            chk("wrap_b3", obs_q[3], {4'd1, 16'h0F00});
        end

        // odd length 5..7
        obs_q.delete();
        do_start(4'd5, 4'd7);
        wait_done(100);
        chk("odd_count", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            chk("odd_b0", obs_q[0][15:0], 16'h0040);
            chk("odd_b1", obs_q[1][15:0], 16'h0024);
            chk("odd_b2", obs_q[2][15:0], 16'h00FF);
        end

        // single register 8, with cycle-exact latency
        obs_q.delete();
        do_start(4'd8, 4'd8);
        chk("single_fetch_rd1", readReg1, 4'd8);
        chk("single_fetch_valid", out_valid, 1'b0);
        chk("single_fetch_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("single_first_valid", out_valid, 1'b1);
        chk("single_word", {out_addr, out_data}, {4'd8, 16'hAAAA});
        @(posedge clk);
        #1;
        chk("single_done", {done, busy, out_valid}, 3'b100);
        @(posedge clk);
        #1;
        chk("single_done_pulse", done, 1'b0);
        chk("single_count", obs_q.size(), 32'd1);

        // start while busy is ignored
        obs_q.delete();
        do_start(4'd4, 4'd11);
        repeat (3) @(posedge clk);
        #1;
        do_start(4'd2, 4'd2);
        wait_done(100);
        chk("busy_start_count", obs_q.size(), 32'd8);
        if (obs_q.size() == 8) begin
            chk("busy_start_first", obs_q[0][19:16], 4'd4);
            chk("busy_start_last", obs_q[7][19:16], 4'd11);
        end

        // async reset while stalled with out_valid high
        ready_mode = 3;
        do_start(4'd0, 4'd15);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) fail_now("stall_valid_timeout");
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", {out_valid, busy, done, readReg1, out_addr, out_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        obs_q.delete();
        do_start(4'd3, 4'd4);
        wait_done(100);
        chk("post_rst_count", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) begin
            chk("post_rst_b0", obs_q[0][15:0], 16'hFF0F);
            chk("post_rst_b1", obs_q[1][15:0], 16'hF0FF);
        end

        // randomized dumps against the model
        for (int it = 0; it < 25; it++) begin
            logic [3:0] f, l, dd;
            for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
            ready_mode = $urandom_range(0, 2);
            f = 4'($urandom);
            l = 4'($urandom);
            dd = l - f;
            do_start(f, l);
            if (dd >= 4'd3 && ($urandom % 3) == 0) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                do_start(4'($urandom), 4'($urandom));
            end
            wait_done(300);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", {busy, out_valid, done}, 3'b000);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side sequencer for the 16x16 general-purpose register file. On a start pulse it walks an inclusive, wrap-around register range through both combinational read ports, two registers per fetch. It then streams each value with its index over a valid/ready interface to the debug/trace path. It only drives the read-address ports and never writes the register file.

Parameters:
ADDR_W, 4, register index width (16 registers)
DATA_W, 16, register data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle dump request; sampled only in IDLE
first_reg  in  ADDR_W  first register of range; sampled with start
last_reg  in  ADDR_W  last register of range, inclusive; sampled with start
readReg1  out  ADDR_W  register-file read address, port 1
readReg2  out  ADDR_W  register-file read address, port 2
readData1  in  DATA_W  register-file read data, port 1 (combinational from readReg1)
readData2  in  DATA_W  register-file read data, port 2 (combinational from readReg2)
out_valid  out  1  stream word valid
out_ready  in  1  consumer accepts word when high with out_valid
out_data  out  DATA_W  register value
out_addr  out  ADDR_W  register index of out_data
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst low, async): state=IDLE; ptr, remaining, buffers, out_data, out_addr, readReg1, readReg2 = 0; out_valid, busy, done = 0.
- Range length N = ((last_reg - first_reg) mod 16) + 1, range 1..16. first==last gives 1 register. last<first wraps through 15->0. first=0, last=15 gives 16 registers. remaining counter is 5 bits.
- States:
  - IDLE: start=1 latches ptr=first_reg, remaining=N; go to FETCH; busy=1 next cycle.
  - FETCH (1 cycle): readReg1=ptr, readReg2=(ptr+1) mod 16.
    - At the clock edge, buf0={ptr,readData1}.
    - If remaining>=2, also buf1={ptr+1,readData2} with buf1_vld=1; otherwise buf1_vld=0.
    - ptr advances by 2 mod 16 (or by 1 when only 1 remains).
    - Go to SEND0.
  - SEND0: out_valid=1, out_{addr,data}=buf0.
    - On out_valid&&out_ready: remaining-=1.
    - If buf1_vld, go to SEND1.
    - Else if remaining becomes 0, go to DONE; otherwise go to FETCH.
  - SEND1: out_valid=1, out=buf1.
    - On handshake: remaining-=1.
    - Go to DONE if remaining becomes 0, else FETCH.
  - DONE (1 cycle): done=1, busy=0 same cycle, out_valid=0. Go to IDLE.
- Outside FETCH, readReg1/readReg2 hold their last values. Outside SEND0/SEND1, out_valid=0.
- Handshake rules:
  - out_data/out_addr are registered and stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
  - No combinational path from out_ready to out_valid/out_data.
- Throughput with out_ready held high: 2 beats per 3 cycles.
- Latency: start high at edge E -> FETCH during cycle after E -> first out_valid in cycle after edge E+1.
- start while busy (not IDLE) is ignored; no queueing.
- Snapshot semantics: values are those present in the register file during the FETCH cycle. Writes landing after that fetch are not reflected in the buffered pair.
- Reset mid-dump: immediate return to IDLE, all outputs to reset values, no done pulse. A subsequent start begins a fresh dump.
- Address arithmetic is mod 16 everywhere. ptr+1 at 15 reads register 0.

Test Plan:
- Full dump with register file at reset contents, start with first=0, last=15, out_ready=1 -> 16 beats, addr 0..15. Data includes r1=0x0F00, r3=0xFF0F, r8=0xAAAA, r12=0xFFFF, r13=0x0002. done pulses once, 1 cycle after beat 15. busy spans the whole dump.
- Backpressure: same dump with out_ready toggling 1,0,0,1 repeating -> identical sequence, no drops or duplicates. out_data/out_addr stable during every stall cycle.
- Wrap range: first=14, last=1 -> exactly 4 beats with addr 14,15,0,1 and data 0x0000,0x0000,0x0000,0x0F00. Odd length first=5, last=7 -> 3 beats: 0x0040,0x0024,0x00FF.
- Single register: first=last=8 -> one beat addr 8 data 0xAAAA. readReg1=8 during the FETCH cycle. done the cycle after acceptance.
- Start while busy: second start with first=2 mid-dump -> ignored; original sequence completes unchanged; no extra beats.
- Async reset mid-dump with out_valid=1 and out_ready=0: assert rst low -> out_valid, busy, done = 0 immediately, no done pulse. After release, a new start first=3, last=4 yields 0xFF0F, 0xF0FF.
